// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller generating PC/IF-ID hold, ID/EX
//               bubble, flush and global freeze, with lost-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  d_rs1_idx,
    input  logic [4:0]  d_rs2_idx,
    input  logic        d_use_rs1,
    input  logic        d_use_rs2,
    input  logic [4:0]  e_rd_idx,
    input  logic        e_is_load,
    input  logic        e_is_muldiv,
    input  logic        e_jb,
    input  logic        m_req,
    input  logic        m_ready,
    output logic        pc_hold,
    output logic        regd_hold,
    output logic        rege_bubble,
    output logic        flush,
    output logic        freeze,
    output logic        muldiv_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [0:0] {
        c_run    = 1'b0,
        c_muldiv = 1'b1
    } state_t;

    localparam logic [7:0]  c_cnt_init = 8'(MULDIV_LAT - 1);
    localparam logic [31:0] c_cnt_max  = 32'hFFFF_FFFF;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_md_done;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic w_ld_use;
    logic w_md_start;
    logic w_mem_wait;
    logic w_freeze;
    logic w_flush;
    logic w_bubble;

    assign w_ld_use   = e_is_load && (e_rd_idx != 5'd0) &&
                        ((d_use_rs1 && (d_rs1_idx == e_rd_idx)) ||
                         (d_use_rs2 && (d_rs2_idx == e_rd_idx)));
    assign w_md_start = (r_state == c_run) && e_is_muldiv && !r_md_done;
    assign w_mem_wait = m_req && !m_ready;

    // Freeze dominates everything; a branch in turn masks the load-use bubble.
    assign w_freeze = w_mem_wait || w_md_start || (r_state == c_muldiv);
    assign w_flush  = !w_freeze && e_jb;
    assign w_bubble = !w_freeze && !e_jb && w_ld_use;

    always_comb begin
        pc_hold     = 1'b0;
        regd_hold   = 1'b0;
        rege_bubble = 1'b0;
        flush       = 1'b0;
        freeze      = 1'b0;
        muldiv_busy = 1'b0;
        if (!rst) begin
            pc_hold     = w_bubble;
            regd_hold   = w_bubble;
            rege_bubble = w_bubble;
            flush       = w_flush;
            freeze      = w_freeze;
            muldiv_busy = (r_state == c_muldiv);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_run;
            r_cnt       <= 8'd0;
            r_md_done   <= 1'b0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            case (r_state)
                c_run: begin
                    if (w_md_start) begin
                        r_state <= c_muldiv;
                        r_cnt   <= c_cnt_init;
                    end else if (!w_freeze) begin
                        // The completed op advances out of E on this edge.
                        r_md_done <= 1'b0;
                    end
                end
                c_muldiv: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state   <= c_run;
                        r_md_done <= 1'b1;
                    end
                end
                default: r_state <= c_run;
            endcase

            if ((w_freeze || w_bubble) && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios plus
//               randomized traffic against a cycle-indexed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  d_rs1_idx, d_rs2_idx, e_rd_idx;
    logic        d_use_rs1, d_use_rs2, e_is_load, e_is_muldiv, e_jb, m_req, m_ready;
    logic        pc_hold, regd_hold, rege_bubble, flush, freeze, muldiv_busy;
    logic [31:0] stall_cnt, flush_cnt;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .d_rs1_idx(d_rs1_idx), .d_rs2_idx(d_rs2_idx),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_rd_idx(e_rd_idx), .e_is_load(e_is_load), .e_is_muldiv(e_is_muldiv),
        .e_jb(e_jb), .m_req(m_req), .m_ready(m_ready),
        .pc_hold(pc_hold), .regd_hold(regd_hold), .rege_bubble(rege_bubble),
        .flush(flush), .freeze(freeze), .muldiv_busy(muldiv_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a mul/div started on cycle s freezes cycles s..s+LAT-1,
    // and the same op cannot restart until the pipeline has advanced once.
    int          cyc    = 0;
    int          md_s   = -1000;
    bit          served = 1'b0;
    logic [31:0] m_stall = 0, m_flush = 0;

    always @(negedge clk) begin
        bit busy, start, memw, frz, fl, lu, bub;
        if (rst) begin
            chk("rst_outs", {26'd0, pc_hold, regd_hold, rege_bubble, flush, freeze, muldiv_busy}, 32'd0);
            chk("rst_stall_cnt", stall_cnt, 32'd0);
            chk("rst_flush_cnt", flush_cnt, 32'd0);
            md_s = -1000; served = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            busy  = (cyc > md_s) && (cyc < md_s + LAT);
            start = !busy && e_is_muldiv && !served;
            memw  = m_req && !m_ready;
            frz   = memw || start || busy;
            fl    = !frz && e_jb;
            lu    = e_is_load && (e_rd_idx != 0) &&
                    ((d_use_rs1 && d_rs1_idx == e_rd_idx) || (d_use_rs2 && d_rs2_idx == e_rd_idx));
            bub   = !frz && !e_jb && lu;
            chk("m_pc_hold", {31'd0, pc_hold}, {31'd0, bub});
            chk("m_regd_hold", {31'd0, regd_hold}, {31'd0, bub});
            chk("m_rege_bubble", {31'd0, rege_bubble}, {31'd0, bub});
            chk("m_flush", {31'd0, flush}, {31'd0, fl});
            chk("m_freeze", {31'd0, freeze}, {31'd0, frz});
            chk("m_muldiv_busy", {31'd0, muldiv_busy}, {31'd0, busy});
            chk("m_stall_cnt", stall_cnt, m_stall);
            chk("m_flush_cnt", flush_cnt, m_flush);
            if (start) begin
                md_s = cyc; served = 1'b1;
            end else if (!busy && !frz) begin
                served = 1'b0;
            end
            if ((frz || bub) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (fl && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end
        cyc++;
    end

    task automatic idle();
        d_rs1_idx = 0; d_rs2_idx = 0; d_use_rs1 = 0; d_use_rs2 = 0;
        e_rd_idx = 0; e_is_load = 0; e_is_muldiv = 0; e_jb = 0; m_req = 0; m_ready = 0;
    endtask

    task automatic next(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); #1; endtask

    task automatic load_use(input logic [4:0] rd);
        idle(); e_is_load = 1; e_rd_idx = rd; d_use_rs1 = 1; d_rs1_idx = 5;
    endtask

    task automatic md_run(output logic [4:0] fpat, output logic [4:0] bpat);
        for (int i = 0; i < 5; i++) begin
            next(); idle(); e_is_muldiv = 1;
            mid(); fpat[i] = freeze; bpat[i] = muldiv_busy;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] fp, bp;
        idle();
        repeat (3) @(posedge clk);
        #1; mid();
        chk("reset_freeze", {31'd0, freeze}, 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        next(); rst = 0;

        // Load-use on rs1
        next(); load_use(5'd5);
        mid(); chk("lu_bubble", {29'd0, pc_hold, regd_hold, rege_bubble}, 32'h7);
        next(); idle();
        mid(); chk("lu_drop", {31'd0, rege_bubble}, 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // rd = x0 never hazards
        next(); load_use(5'd0); d_rs1_idx = 0;
        mid(); chk("x0_bubble", {29'd0, pc_hold, regd_hold, rege_bubble}, 32'd0);
        next(); idle();
        mid(); chk("x0_stall_cnt", stall_cnt, 32'd1);

        // Mul/div held in E through its departure cycle
        md_run(fp, bp);
        chk("md_freeze_pat", {27'd0, fp}, 32'h0F);
        chk("md_busy_pat", {27'd0, bp}, 32'h0E);
        next(); idle();
        mid(); chk("md_stall_cnt", stall_cnt, 32'd5);

        // Branch beats load-use
        next(); load_use(5'd5); e_jb = 1;
        mid(); chk("jb_lu", {29'd0, flush, rege_bubble, pc_hold}, 32'h4);
        next(); idle();
        mid(); chk("jb_flush_cnt", flush_cnt, 32'd1);

        // Memory wait beats branch
        for (int i = 0; i < 3; i++) begin
            next(); idle(); m_req = 1; m_ready = 0; e_jb = 1;
            mid(); chk("mw_freeze_flush", {30'd0, freeze, flush}, 32'h2);
        end
        next(); m_ready = 1;
        mid(); chk("mw_release", {30'd0, freeze, flush}, 32'h1);
        next(); idle();
        mid(); chk("mw_stall_cnt", stall_cnt, 32'd8);
        chk("mw_flush_cnt", flush_cnt, 32'd2);

        // Async reset during the second MULDIV cycle
        next(); idle(); e_is_muldiv = 1; mid();
        next(); mid();
        next(); mid(); chk("rm_busy_before", {31'd0, muldiv_busy}, 32'd1);
        rst = 1; idle(); #1;
        chk("rm_outs", {30'd0, muldiv_busy, freeze}, 32'd0);
        chk("rm_cnts", stall_cnt | flush_cnt, 32'd0);
        next(); next(); rst = 0;
        md_run(fp, bp);
        chk("rm_refreeze", {27'd0, fp}, 32'h0F);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            next();
            rst         = ($urandom_range(0, 199) == 0);
            d_rs1_idx   = 5'($urandom_range(0, 3));
            d_rs2_idx   = 5'($urandom_range(0, 3));
            e_rd_idx    = 5'($urandom_range(0, 3));
            d_use_rs1   = 1'($urandom_range(0, 1));
            d_use_rs2   = 1'($urandom_range(0, 1));
            e_is_load   = ($urandom_range(0, 2) == 0);
            e_is_muldiv = ($urandom_range(0, 7) == 0);
            e_jb        = ($urandom_range(0, 5) == 0);
            m_req       = ($urandom_range(0, 3) == 0);
            m_ready     = 1'($urandom_range(0, 1));
        end
        next(); rst = 0; idle();
        mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
